// File: rtl/ring_counter_param.sv
// Parametrised ring / Johnson counter.
// Keeps a binary position index plus a CLEARED/RUN state and decodes them into
// an N-bit one-hot (ring) or thermometer (Johnson) word. State updates on the
// falling clock edge; clearn clears everything asynchronously.
module ring_counter_param #(
    parameter int unsigned N        = 8,
    parameter int unsigned JOHNSON  = 0,
    parameter int unsigned INIT_POS = 0,
    localparam int unsigned S       = (JOHNSON != 0) ? 2 * N : N,
    localparam int unsigned PW      = $clog2(S)
) (
    input  logic          clk,
    input  logic          clearn,
    input  logic          presetn,
    input  logic          en,
    input  logic          dir,
    input  logic          load,
    input  logic [PW-1:0] load_pos,
    output logic [N-1:0]  count,
    output logic [PW-1:0] pos,
    output logic          running,
    output logic          wrap,
    output logic          err
);

    localparam logic [PW-1:0] LastPos = PW'(S - 1);
    localparam logic [PW-1:0] InitPos = PW'(INIT_POS);

    typedef enum logic [0:0] {StCleared, StRun} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pos_q, pos_d;
    logic          wrap_q, wrap_d;
    logic          err_q, err_d;
    logic          load_ok;
    int unsigned   pos_int;

    // Index widths may exceed S when S is not a power of two.
    assign load_ok = (32'(load_pos) < S);
    assign pos_int = 32'(pos_q);

    // Next-state: preset beats load beats enable; otherwise hold.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        wrap_d  = 1'b0;
        err_d   = err_q;
        if (!presetn) begin
            state_d = StRun;
            pos_d   = LastPos;
        end else if (load) begin
            if (load_ok) begin
                state_d = StRun;
                pos_d   = load_pos;
            end else begin
                // Bad load is flagged and otherwise ignored.
                err_d = 1'b1;
            end
        end else if (en) begin
            if (state_q == StCleared) begin
                // First enable only enters RUN at the start index, no step.
                state_d = StRun;
                pos_d   = InitPos;
            end else if (!dir) begin
                if (pos_q == LastPos) begin
                    pos_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    pos_d = pos_q + PW'(1);
                end
            end else begin
                if (pos_q == '0) begin
                    pos_d  = LastPos;
                    wrap_d = 1'b1;
                end else begin
                    pos_d = pos_q - PW'(1);
                end
            end
        end
    end

    // State register: falling-edge clocked, asynchronous active-low clear.
    always_ff @(negedge clk or negedge clearn) begin
        if (!clearn) begin
            state_q <= StCleared;
            pos_q   <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    // Output decode: all zeros while cleared, else one-hot or thermometer.
    always_comb begin
        count = '0;
        if (state_q == StRun) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (JOHNSON == 0) begin
                    count[i] = (pos_int == i);
                end else if (pos_int <= N) begin
                    count[i] = (i < pos_int);
                end else begin
                    count[i] = (i >= pos_int - N);
                end
            end
        end
    end

    assign pos     = pos_q;
    assign running = (state_q == StRun);
    assign wrap    = wrap_q;
    assign err     = err_q;

endmodule

// File: tb/tb_ring_counter_param.sv
// Directed bench for ring_counter_param: N=4 ring, N=4 Johnson and
// N=6 ring (INIT_POS=2) instances share clock and controls.
module tb_ring_counter_param;

    logic       clk;
    logic       clearn;
    logic       presetn;
    logic       en;
    logic       dir;
    logic       load;
    logic [2:0] load_pos;

    logic [3:0] r4_count;
    logic [1:0] r4_pos;
    logic       r4_running, r4_wrap, r4_err;
    logic [3:0] j4_count;
    logic [2:0] j4_pos;
    logic       j4_running, j4_wrap, j4_err;
    logic [5:0] r6_count;
    logic [2:0] r6_pos;
    logic       r6_running, r6_wrap, r6_err;

    int n_checks = 0;
    int n_fail   = 0;

    ring_counter_param #(.N(4), .JOHNSON(0), .INIT_POS(0)) u_ring4 (
        .clk      (clk),
        .clearn   (clearn),
        .presetn  (presetn),
        .en       (en),
        .dir      (dir),
        .load     (load),
        .load_pos (load_pos[1:0]),
        .count    (r4_count),
        .pos      (r4_pos),
        .running  (r4_running),
        .wrap     (r4_wrap),
        .err      (r4_err)
    );

    ring_counter_param #(.N(4), .JOHNSON(1), .INIT_POS(0)) u_john4 (
        .clk      (clk),
        .clearn   (clearn),
        .presetn  (presetn),
        .en       (en),
        .dir      (dir),
        .load     (load),
        .load_pos (load_pos),
        .count    (j4_count),
        .pos      (j4_pos),
        .running  (j4_running),
        .wrap     (j4_wrap),
        .err      (j4_err)
    );

    ring_counter_param #(.N(6), .JOHNSON(0), .INIT_POS(2)) u_ring6 (
        .clk      (clk),
        .clearn   (clearn),
        .presetn  (presetn),
        .en       (en),
        .dir      (dir),
        .load     (load),
        .load_pos (load_pos),
        .count    (r6_count),
        .pos      (r6_pos),
        .running  (r6_running),
        .wrap     (r6_wrap),
        .err      (r6_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One active (falling) edge, then return on the rising edge to sample.
    task automatic tick();
        @(negedge clk);
        @(posedge clk);
    endtask

    task automatic pulse_clear();
        clearn = 1'b0;
        #1;
        clearn = 1'b1;
    endtask

    logic [3:0] john_seq [9];
    logic [5:0] r6_exp_pos;

    initial begin
        john_seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111,
                     4'b1110, 4'b1100, 4'b1000, 4'b0000};
        clearn   = 1'b0;
        presetn  = 1'b1;
        en       = 1'b0;
        dir      = 1'b0;
        load     = 1'b0;
        load_pos = '0;
        @(posedge clk);
        @(posedge clk);

        // Reset state.
        check("rst_count", r4_count, 4'b0000);
        check("rst_pos", r4_pos, 2'd0);
        check("rst_running", r4_running, 1'b0);
        check("rst_wrap", r4_wrap, 1'b0);
        check("rst_err", r4_err, 1'b0);

        // Ring up-count with wrap.
        clearn = 1'b1;
        en     = 1'b1;
        tick();
        check("t1_entry_count", r4_count, 4'b0001);
        check("t1_entry_wrap", r4_wrap, 1'b0);
        check("t1_running", r4_running, 1'b1);
        tick();
        check("t1_c2", r4_count, 4'b0010);
        tick();
        check("t1_c3", r4_count, 4'b0100);
        tick();
        check("t1_c4", r4_count, 4'b1000);
        check("t1_c4_wrap", r4_wrap, 1'b0);
        tick();
        check("t1_wrap_count", r4_count, 4'b0001);
        check("t1_wrap", r4_wrap, 1'b1);

        // Ring down-count wraps 0 -> 3.
        dir = 1'b1;
        tick();
        check("t2_count", r4_count, 4'b1000);
        check("t2_pos", r4_pos, 2'd3);
        check("t2_wrap", r4_wrap, 1'b1);
        tick();
        check("t2_next_count", r4_count, 4'b0100);
        check("t2_next_wrap", r4_wrap, 1'b0);

        // Johnson sequence from cleared.
        en  = 1'b0;
        dir = 1'b0;
        pulse_clear();
        check("t3_clr_count", j4_count, 4'b0000);
        check("t3_clr_running", j4_running, 1'b0);
        en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("t3_count%0d", i), j4_count, john_seq[i]);
            check($sformatf("t3_wrap%0d", i), j4_wrap, (i == 8) ? 1'b1 : 1'b0);
        end

        // Preset beats load and enable.
        presetn  = 1'b0;
        load     = 1'b1;
        load_pos = 3'd1;
        tick();
        check("t4_pos", r4_pos, 2'd3);
        check("t4_count", r4_count, 4'b1000);
        check("t4_wrap", r4_wrap, 1'b0);
        check("t4_j_pos", j4_pos, 3'd7);
        presetn  = 1'b1;
        load_pos = 3'd2;
        en       = 1'b0;
        tick();
        check("t4_load_count", r4_count, 4'b0100);
        check("t4_load_pos", r4_pos, 2'd2);
        load = 1'b0;

        // Out-of-range load on N=6 ring.
        pulse_clear();
        load     = 1'b1;
        load_pos = 3'd1;
        tick();
        check("t5_load_pos", r6_pos, 3'd1);
        check("t5_load_count", r6_count, 6'b000010);
        load_pos = 3'd7;
        tick();
        check("t5_err", r6_err, 1'b1);
        check("t5_hold_pos", r6_pos, 3'd1);
        check("t5_hold_count", r6_count, 6'b000010);
        load_pos = 3'd6;
        tick();
        check("t5_bound_pos", r6_pos, 3'd1);
        load = 1'b0;
        en   = 1'b1;
        tick();
        check("t5_step_pos", r6_pos, 3'd2);
        check("t5_err_sticky", r6_err, 1'b1);
        tick();
        check("t5_step2_count", r6_count, 6'b001000);
        check("t5_err_sticky2", r6_err, 1'b1);
        en = 1'b0;
        pulse_clear();
        check("t5_err_clr", r6_err, 1'b0);

        // Mid-run async clear, then INIT_POS entry.
        load     = 1'b1;
        load_pos = 3'd4;
        tick();
        load = 1'b0;
        check("t6_pre_pos", r6_pos, 3'd4);
        clearn = 1'b0;
        #1;
        check("t6_async_count", r6_count, 6'b000000);
        check("t6_async_pos", r6_pos, 3'd0);
        check("t6_async_running", r6_running, 1'b0);
        clearn = 1'b1;
        en     = 1'b1;
        tick();
        check("t6_init_pos", r6_pos, 3'd2);
        check("t6_init_count", r6_count, 6'b000100);
        check("t6_init_wrap", r6_wrap, 1'b0);

        // Down-count across zero on N=6.
        dir = 1'b1;
        r6_exp_pos = 6'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            r6_exp_pos = (r6_exp_pos == 6'd0) ? 6'd5 : r6_exp_pos - 6'd1;
            check($sformatf("t6_down_pos%0d", i), r6_pos, r6_exp_pos);
            check($sformatf("t6_down_wrap%0d", i), r6_wrap, (i == 2) ? 1'b1 : 1'b0);
        end
        check("t6_down_count", r6_count, 6'b100000);

        // Hold with enable low.
        en = 1'b0;
        tick();
        check("hold_pos", r6_pos, 3'd5);
        check("hold_wrap", r6_wrap, 1'b0);
        check("hold_count", r6_count, 6'b100000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
